// File: rtl/traceback.sv
// Traceback walker: follows direction codes from the max cell back to a STOP
// or matrix edge, emitting one alignment op per step. Optional TB_ALN_LEN_EN adds aln_len.
module traceback #(
  parameter int N      = 8,
  parameter int LOG_N  = 3,
  parameter int DIR_W  = 2,
  parameter int ADDR_W = 10,
  parameter int MEM_W  = 7
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 tb_valid,
  input  logic                 array_num,
  input  logic [ADDR_W-1:0]    tb_x,
  input  logic [ADDR_W-1:0]    tb_y,
  output logic                 tb_busy,
  output logic [MEM_W-1:0]     mem_block_num,
  output logic [ADDR_W-1:0]    column_num,
  input  logic [N*DIR_W-1:0]   column_k0,
  input  logic [N*DIR_W-1:0]   column_k1,
  output logic                 op_valid,
  output logic [1:0]           op_code,
  output logic                 op_last,
  output logic                 op_array,
`ifdef TB_ALN_LEN_EN
  output logic [ADDR_W:0]      aln_len,
`endif
  input  logic                 op_ready
);

  localparam logic [1:0] CODE_STOP = 2'b00;
  localparam logic [1:0] CODE_DIAG = 2'b01;
  localparam logic [1:0] CODE_UP   = 2'b10;
  localparam logic [1:0] CODE_LEFT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_x;
  logic [ADDR_W-1:0]   r_y;
  logic [ADDR_W-1:0]   w_nx;
  logic [ADDR_W-1:0]   w_ny;
  logic                r_busy;
  logic                r_op_valid;
  logic [1:0]          r_op_code;
  logic                r_op_last;
  logic                r_op_array;
  logic [MEM_W-1:0]    r_mem_block;
  logic [ADDR_W-1:0]   r_column;
  logic [LOG_N-1:0]    w_lane;
  logic [DIR_W-1:0]    w_lane_code;
  logic [1:0]          w_code;
  logic                w_moves_x;
  logic                w_moves_y;
  logic                w_last;
  logic                w_unused;

  // The K-1 column port is part of the shared memory interface but unused here.
  assign w_unused    = ^column_k1;
  assign w_lane      = r_y[LOG_N-1:0];
  assign w_lane_code = column_k0[int'(w_lane)*DIR_W +: DIR_W];
  assign w_code      = w_lane_code[1:0];

  // Terminal-cell detection for the freshly read code, plus which axes the held op moves.
  always_comb begin
    w_moves_x = 1'b0;
    w_moves_y = 1'b0;
    w_last    = 1'b0;
    if ((w_code == CODE_DIAG) || (w_code == CODE_LEFT)) begin
      w_last = (r_x == {ADDR_W{1'b0}});
    end else begin
      w_last = 1'b0;
    end
    if ((w_code == CODE_DIAG) || (w_code == CODE_UP)) begin
      w_last = w_last | (r_y == {ADDR_W{1'b0}});
    end else begin
      w_last = w_last;
    end
    w_moves_x = (r_op_code == CODE_DIAG) || (r_op_code == CODE_LEFT);
    w_moves_y = (r_op_code == CODE_DIAG) || (r_op_code == CODE_UP);
  end

  // Next-state and next-coordinate logic.
  always_comb begin
    w_next = r_state;
    w_nx   = r_x;
    w_ny   = r_y;
    case (r_state)
      S_IDLE: begin
        if (tb_valid) begin
          w_next = S_FETCH;
          w_nx   = tb_x;
          w_ny   = tb_y;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_FETCH: w_next = S_WAIT;
      S_WAIT: begin
        if (w_code == CODE_STOP) begin
          w_next = S_DONE;
        end else begin
          w_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!op_ready) begin
          w_next = S_EMIT;
        end else if (r_op_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_FETCH;
          w_nx   = w_moves_x ? (r_x - {{(ADDR_W-1){1'b0}}, 1'b1}) : r_x;
          w_ny   = w_moves_y ? (r_y - {{(ADDR_W-1){1'b0}}, 1'b1}) : r_y;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, coordinates and all registered outputs.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= S_IDLE;
      r_x         <= {ADDR_W{1'b0}};
      r_y         <= {ADDR_W{1'b0}};
      r_busy      <= 1'b0;
      r_op_valid  <= 1'b0;
      r_op_code   <= 2'b00;
      r_op_last   <= 1'b0;
      r_op_array  <= 1'b0;
      r_mem_block <= {MEM_W{1'b0}};
      r_column    <= {ADDR_W{1'b0}};
    end else begin
      r_state    <= w_next;
      r_x        <= w_nx;
      r_y        <= w_ny;
      r_busy     <= (w_next != S_IDLE);
      r_op_valid <= (w_next == S_EMIT);
      if ((r_state == S_WAIT) && (w_next == S_EMIT)) begin
        r_op_code <= w_code;
        r_op_last <= w_last;
      end else if (w_next != S_EMIT) begin
        r_op_last <= 1'b0;
      end
      // Address is presented for the whole FETCH cycle and then held.
      if (w_next == S_FETCH) begin
        r_mem_block <= w_ny[ADDR_W-1:LOG_N];
        r_column    <= w_nx;
      end
      if ((r_state == S_IDLE) && tb_valid) begin
        r_op_array <= array_num;
      end
    end
  end

`ifdef TB_ALN_LEN_EN
  logic [ADDR_W:0] r_aln_len;

  // Path length: cleared on start, bumped on every op transfer.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_aln_len <= {(ADDR_W+1){1'b0}};
    end else if ((r_state == S_IDLE) && tb_valid) begin
      r_aln_len <= {(ADDR_W+1){1'b0}};
    end else if (r_op_valid && op_ready) begin
      r_aln_len <= r_aln_len + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  assign aln_len = r_aln_len;
`endif

  assign tb_busy       = r_busy;
  assign op_valid      = r_op_valid;
  assign op_code       = r_op_code;
  assign op_last       = r_op_last;
  assign op_array      = r_op_array;
  assign mem_block_num = r_mem_block;
  assign column_num    = r_column;

endmodule

// File: tb/tb_traceback.sv
// Randomized self-checking bench for traceback: a grid-walk model predicts the op
// sequence, read addresses and busy duration; a per-cycle compare checks the DUT.
module tb_traceback;
  localparam int N = 8, LOG_N = 3, DIR_W = 2, ADDR_W = 10, MEM_W = 7, G = 32;

  logic clk = 1'b0;
  logic reset_i, tb_valid, array_num, op_ready;
  logic [ADDR_W-1:0] tb_x, tb_y, column_num;
  logic tb_busy, op_valid, op_last, op_array;
  logic [MEM_W-1:0] mem_block_num;
  logic [N*DIR_W-1:0] column_k0, column_k1, mem_data;
  logic [1:0] op_code;
`ifdef TB_ALN_LEN_EN
  logic [ADDR_W:0] aln_len;
`endif

  traceback #(.N(N), .LOG_N(LOG_N), .DIR_W(DIR_W), .ADDR_W(ADDR_W), .MEM_W(MEM_W)) dut (
    .clk(clk), .reset_i(reset_i), .tb_valid(tb_valid), .array_num(array_num),
    .tb_x(tb_x), .tb_y(tb_y), .tb_busy(tb_busy), .mem_block_num(mem_block_num),
    .column_num(column_num), .column_k0(column_k0), .column_k1(column_k1),
    .op_valid(op_valid), .op_code(op_code), .op_last(op_last), .op_array(op_array),
`ifdef TB_ALN_LEN_EN
    .aln_len(aln_len),
`endif
    .op_ready(op_ready));

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  logic [1:0] grid [0:G-1][0:G-1];   // grid[x][y] = direction code
  int q_code[$], q_last[$], q_x[$], q_y[$];
  int exp_k, exp_stop_end, end_x, end_y;
  int busy_cnt, stall_cnt, ready_mode, stall_left, cur_arr;
  bit chk_en = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Walk the grid from (sx,sy): STOP ends with no op, an edge-crossing move is the last op.
  task automatic model(input int sx, input int sy);
    int x, y, c, last;
    x = sx; y = sy;
    q_code.delete(); q_last.delete(); q_x.delete(); q_y.delete();
    exp_k = 0; exp_stop_end = 0;
    for (int s = 0; s < 4*G; s++) begin
      c = int'(grid[x][y]); end_x = x; end_y = y;
      if (c == 0) begin exp_stop_end = 1; break; end
      last = (((c == 1) || (c == 3)) && x == 0) || (((c == 1) || (c == 2)) && y == 0) ? 1 : 0;
      q_code.push_back(c); q_last.push_back(last); q_x.push_back(x); q_y.push_back(y);
      exp_k++;
      if (last != 0) break;
      if (c == 1 || c == 3) x--;
      if (c == 1 || c == 2) y--;
    end
  endtask

  task automatic fill_random();
    int r;
    for (int x = 0; x < G; x++)
      for (int y = 0; y < G; y++) begin
        r = $urandom_range(0, 9);
        grid[x][y] = (r == 0) ? 2'b00 : 2'(r % 3 + 1);
      end
  endtask

  // Synchronous-read memory: address seen at an edge, lane data valid the next cycle.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (int'(column_num) < G && int'(mem_block_num) * N + i < G)
        mem_data[i*DIR_W +: DIR_W] = grid[column_num][int'(mem_block_num) * N + i];
      else
        mem_data[i*DIR_W +: DIR_W] = 2'b00;
    end
    column_k0 <= mem_data;
  end

  // Downstream readiness: always ready, random, or a fixed-length stall on the first op.
  initial begin
    op_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) op_ready = ($urandom_range(0, 2) != 0);
      else if (ready_mode == 2 && op_valid && stall_left > 0) begin op_ready = 1'b0; stall_left--; end
      else op_ready = 1'b1;
    end
  end

  // Per-cycle compare of the op stream and address against the model's expected path.
  always @(negedge clk) begin
    if (chk_en && reset_i) begin
      if (tb_busy) busy_cnt++;
      if (op_valid) begin
        if (q_code.size() == 0) chk("unexpected_op", 1, 0);
        else begin
          chk("op_code", int'(op_code), q_code[0]);
          chk("op_last", int'(op_last), q_last[0]);
          chk("op_array", int'(op_array), cur_arr);
          chk("op_busy", int'(tb_busy), 1);
          chk("op_col", int'(column_num), q_x[0]);
          chk("op_blk", int'(mem_block_num), q_y[0] >> LOG_N);
          if (op_ready) begin
            void'(q_code.pop_front()); void'(q_last.pop_front());
            void'(q_x.pop_front()); void'(q_y.pop_front());
          end else stall_cnt++;
        end
      end
    end
  end

  task automatic run_trace(input int sx, input int sy, input int arr, input int rmode, input bit inject);
    bit done;
    model(sx, sy);
    ready_mode = rmode; stall_left = (rmode == 2) ? 4 : 0;
    cur_arr = arr; stall_cnt = 0; busy_cnt = 0;
    @(posedge clk); #2;
    tb_valid = 1'b1; tb_x = ADDR_W'(sx); tb_y = ADDR_W'(sy); array_num = arr[0];
    @(posedge clk); #2;
    tb_valid = 1'b0; tb_x = ADDR_W'($urandom_range(0, G-1)); tb_y = ADDR_W'($urandom_range(0, G-1));
    array_num = ~arr[0];
    chk("busy_rise", int'(tb_busy), 1);
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      tb_valid = (inject && i == 3) ? 1'b1 : 1'b0;
      @(posedge clk); #2;
      if (!tb_busy) done = 1'b1;
    end
    tb_valid = 1'b0;
    chk("trace_timeout", int'(done), 1);
    chk("busy_cycles", busy_cnt, 3*exp_k + (exp_stop_end != 0 ? 3 : 1) + stall_cnt);
    chk("ops_left", q_code.size(), 0);
    chk("end_col", int'(column_num), end_x);
    chk("end_blk", int'(mem_block_num), end_y >> LOG_N);
`ifdef TB_ALN_LEN_EN
    chk("aln_len", int'(aln_len), exp_k);
`endif
  endtask

  initial begin
    reset_i = 1'b0; tb_valid = 1'b0; array_num = 1'b0; tb_x = '0; tb_y = '0;
    column_k1 = '0; ready_mode = 0; stall_left = 0; cur_arr = 0;
    fill_random();
    repeat (2) @(posedge clk); #2;
    chk("rst_busy", int'(tb_busy), 0);
    chk("rst_valid", int'(op_valid), 0);
    chk("rst_code", int'(op_code), 0);
    chk("rst_addr", int'(mem_block_num) + int'(column_num), 0);
    reset_i = 1'b1;

    // Diagonal to a STOP at the origin, with an ignored mid-trace start pulse.
    grid[3][3] = 2'b01; grid[2][2] = 2'b01; grid[1][1] = 2'b01; grid[0][0] = 2'b00;
    model(3, 3);
    chk("model_diag_k", exp_k, 3);
    chk("model_diag_stop", exp_stop_end, 1);
    run_trace(3, 3, 1, 0, 1'b1);
    chk("diag_busy", busy_cnt, 12);

    // Edge cell: DIAG at x=0 is the last op.
    grid[0][2] = 2'b01;
    model(0, 2);
    chk("model_edge_last", q_last[0], 1);
    run_trace(0, 2, 0, 0, 1'b0);
    chk("edge_busy", busy_cnt, 4);

    // Block/lane addressing across a block boundary.
    grid[5][8] = 2'b10; grid[5][7] = 2'b00; grid[5][9] = 2'b01; grid[5][15] = 2'b01;
    fork
      run_trace(5, 8, 1, 0, 1'b0);
      begin
        @(posedge clk); @(posedge clk); #2;
        chk("blk_first", int'(mem_block_num), 1);
        chk("col_first", int'(column_num), 5);
      end
    join
    chk("blk_second", int'(mem_block_num), 0);

    // Four-cycle stall on the first op.
    grid[3][3] = 2'b01; grid[2][2] = 2'b01; grid[1][1] = 2'b01; grid[0][0] = 2'b00;
    run_trace(3, 3, 0, 2, 1'b0);
    chk("stall_len", stall_cnt, 4);

    // STOP on the very first cell.
    grid[9][4] = 2'b00;
    run_trace(9, 4, 1, 0, 1'b0);
    chk("stop_first_busy", busy_cnt, 3);

    // Reset asserted during WAIT aborts the path.
    grid[10][10] = 2'b01; grid[9][9] = 2'b01;
    @(posedge clk); #2; tb_valid = 1'b1; tb_x = 10'd10; tb_y = 10'd10;
    @(posedge clk); #2; tb_valid = 1'b0;
    @(posedge clk); #2;
    chk_en = 1'b0; reset_i = 1'b0; #1;
    chk("abort_busy", int'(tb_busy), 0);
    chk("abort_valid", int'(op_valid), 0);
    chk("abort_addr", int'(mem_block_num) + int'(column_num), 0);
`ifdef TB_ALN_LEN_EN
    chk("abort_len", int'(aln_len), 0);
`endif
    @(posedge clk); #2; reset_i = 1'b1;
    q_code.delete(); q_last.delete(); q_x.delete(); q_y.delete();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    run_trace(10, 10, 0, 0, 1'b0);

    // Random grids, starts and downstream readiness.
    for (int t = 0; t < 25; t++) begin
      fill_random();
      run_trace($urandom_range(0, G-1), $urandom_range(0, G-1), $urandom_range(0, 1),
                $urandom_range(0, 1), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
